// File: rtl/layer_batch_scheduler_if.sv
// Handshake bundle between the BRAM loaders, the convolution engine and layer_batch_scheduler.
interface layer_batch_scheduler_if #(
   parameter int LAYER_W = 2,
   parameter int BATCH_W = 3
);
   logic               weight_write_done;
   logic               ifmap_write_done;
   logic               batch_complete_signal;
   logic               ext_scheduler_start;
   logic               err_clr;
   logic               final_start_signal;
   logic               auto_start_active;
   logic [BATCH_W-1:0] current_batch_id;
   logic [LAYER_W-1:0] current_layer_id;
   logic               layer_transition;
   logic               clear_output_bram;
   logic               all_batches_complete;
   logic               all_layers_complete;
   logic               data_load_ready;
   logic               busy;
   logic               load_overrun_err;
   logic               watchdog_err;

   modport master (
      output weight_write_done, ifmap_write_done, batch_complete_signal,
             ext_scheduler_start, err_clr,
      input  final_start_signal, auto_start_active, current_batch_id, current_layer_id,
             layer_transition, clear_output_bram, all_batches_complete,
             all_layers_complete, data_load_ready, busy, load_overrun_err, watchdog_err
   );

   modport slave (
      input  weight_write_done, ifmap_write_done, batch_complete_signal,
             ext_scheduler_start, err_clr,
      output final_start_signal, auto_start_active, current_batch_id, current_layer_id,
             layer_transition, clear_output_bram, all_batches_complete,
             all_layers_complete, data_load_ready, busy, load_overrun_err, watchdog_err
   );
endinterface

// File: rtl/layer_batch_scheduler.sv
// Layer/batch sequencer: reuses the ifmap across a layer's batches and issues one start per batch.
// Optional RUN-state watchdog enabled by defining SCHED_WATCHDOG_EN.
module layer_batch_scheduler #(
   parameter int                            NUM_LAYERS      = 4,
   parameter int                            LAYER_W         = 2,
   parameter int                            BATCH_W         = 3,
   parameter logic [NUM_LAYERS*BATCH_W-1:0] LAYER_MAX_BATCH = 12'h01F,
   parameter int                            CLEAR_CYCLES    = 2,
   parameter int                            WDOG_CYCLES     = 65535
) (
   input  logic                     clk,
   input  logic                     rst,
   layer_batch_scheduler_if.slave   bus
);

   localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_START,
      S_RUN,
      S_NEXT,
      S_LAYER_DONE
   } state_t;

   state_t             r_state, w_state_nxt;
   logic               r_wdone_q, r_idone_q;
   logic               r_ifmap_ld, r_weight_ld;
   logic [LAYER_W-1:0] r_layer, w_layer_nxt;
   logic [BATCH_W-1:0] r_batch, w_batch_nxt;
   logic [CLR_W-1:0]   r_clr_cnt, w_clr_cnt_nxt;
   logic               r_layer_transition, r_all_layers_complete;
   logic               r_overrun_err, r_wdog_err;
   logic               w_lt_nxt, w_alc_nxt;
   logic               w_w_rise, w_i_rise;
   logic               w_enter_start, w_clr_weight, w_clr_ifmap;
   logic               w_ovr_evt, w_wdog_evt;
   logic               w_both_ld, w_last_batch, w_last_layer;
   logic [BATCH_W-1:0] w_max_batch;

   assign w_w_rise     = bus.weight_write_done & ~r_wdone_q;
   assign w_i_rise     = bus.ifmap_write_done  & ~r_idone_q;
   assign w_both_ld    = r_ifmap_ld & r_weight_ld;
   assign w_max_batch  = LAYER_MAX_BATCH[int'(r_layer)*BATCH_W +: BATCH_W];
   assign w_last_batch = (r_batch == w_max_batch);
   assign w_last_layer = (r_layer == LAYER_W'(NUM_LAYERS-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_layer   <= '0;
         r_batch   <= '0;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_layer   <= w_layer_nxt;
         r_batch   <= w_batch_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_layer_nxt   = r_layer;
      w_batch_nxt   = r_batch;
      w_clr_cnt_nxt = r_clr_cnt;
      w_lt_nxt      = 1'b0;
      w_alc_nxt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_both_ld) begin
               w_layer_nxt   = '0;
               w_batch_nxt   = '0;
               w_clr_cnt_nxt = '0;
               w_state_nxt   = (CLEAR_CYCLES == 0) ? S_START : S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (r_clr_cnt == CLR_W'(CLEAR_CYCLES-1)) begin
               w_state_nxt = S_START;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
         end
         S_START: w_state_nxt = S_RUN;
         S_RUN: begin
            if (bus.batch_complete_signal) begin
               if (w_last_batch) begin
                  w_state_nxt = S_LAYER_DONE;
                  w_alc_nxt   = w_last_layer;
               end else begin
                  w_state_nxt = S_NEXT;
               end
            end
         end
         S_NEXT: begin
            // NEXT is only reached with batch below its table entry, so the increment cannot overshoot.
            if (r_weight_ld) begin
               w_batch_nxt = r_batch + 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_LAYER_DONE: begin
            if (w_both_ld) begin
               w_batch_nxt   = '0;
               w_layer_nxt   = w_last_layer ? '0 : r_layer + 1'b1;
               w_lt_nxt      = 1'b1;
               w_clr_cnt_nxt = '0;
               w_state_nxt   = (CLEAR_CYCLES == 0) ? S_START : S_CLEAR;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Batch 0 consumes the fresh ifmap; later batches reuse it and only need new weights.
   assign w_enter_start = (w_state_nxt == S_START) && (r_state != S_START);
   assign w_clr_weight  = w_enter_start;
   assign w_clr_ifmap   = w_enter_start && (w_batch_nxt == '0);
   assign w_ovr_evt     = (w_w_rise & r_weight_ld & ~w_clr_weight)
                        | (w_i_rise & r_ifmap_ld  & ~w_clr_ifmap);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdone_q             <= 1'b0;
         r_idone_q             <= 1'b0;
         r_ifmap_ld            <= 1'b0;
         r_weight_ld           <= 1'b0;
         r_layer_transition    <= 1'b0;
         r_all_layers_complete <= 1'b0;
         r_overrun_err         <= 1'b0;
         r_wdog_err            <= 1'b0;
      end else begin
         r_wdone_q             <= bus.weight_write_done;
         r_idone_q             <= bus.ifmap_write_done;
         r_ifmap_ld            <= (r_ifmap_ld  & ~w_clr_ifmap)  | w_i_rise;
         r_weight_ld           <= (r_weight_ld & ~w_clr_weight) | w_w_rise;
         r_layer_transition    <= w_lt_nxt;
         r_all_layers_complete <= w_alc_nxt;
         r_overrun_err         <= w_ovr_evt  | (r_overrun_err & ~bus.err_clr);
         r_wdog_err            <= w_wdog_evt | (r_wdog_err    & ~bus.err_clr);
      end
   end

`ifdef SCHED_WATCHDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES+1);
   logic [WD_W-1:0] r_wdog_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdog_cnt <= '0;
      end else if (r_state != S_RUN) begin
         r_wdog_cnt <= '0;
      end else if (r_wdog_cnt != WD_W'(WDOG_CYCLES)) begin
         r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
   end

   assign w_wdog_evt = (r_state == S_RUN) && (r_wdog_cnt == WD_W'(WDOG_CYCLES-1));
`else
   // Always false; keeps the timeout parameter referenced when no watchdog is built.
   assign w_wdog_evt = (WDOG_CYCLES < 0);
`endif

   assign bus.auto_start_active    = (r_state == S_START);
   assign bus.final_start_signal   = (r_state == S_START) | bus.ext_scheduler_start;
   assign bus.current_batch_id     = r_batch;
   assign bus.current_layer_id     = r_layer;
   assign bus.layer_transition     = r_layer_transition;
   assign bus.clear_output_bram    = (r_state == S_CLEAR);
   assign bus.all_batches_complete = (r_state == S_LAYER_DONE);
   assign bus.all_layers_complete  = r_all_layers_complete;
   assign bus.data_load_ready      = r_weight_ld;
   assign bus.busy                 = (r_state != S_IDLE) && (r_state != S_LAYER_DONE);
   assign bus.load_overrun_err     = r_overrun_err;
   assign bus.watchdog_err         = r_wdog_err;

endmodule
